// File: rtl/butterfly_operand_loader_if.sv
// Operand bus between the loader and the butterfly datapath.
// Ports: Rea/Ima/Reb/Imb/Rew/Imw operand words, op_valid/op_ready handshake,
//        load_idx (operand currently awaited, 6 while the set is presented).
interface butterfly_operand_loader_if #(
  parameter int n = 8
);
  logic [n-1:0] Rea;
  logic [n-1:0] Ima;
  logic [n-1:0] Reb;
  logic [n-1:0] Imb;
  logic [n-1:0] Rew;
  logic [n-1:0] Imw;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   load_idx;

  // Loader side drives the operand set and consumes the accept.
  modport master (
    output Rea, Ima, Reb, Imb, Rew, Imw, op_valid, load_idx,
    input  op_ready
  );

  // Butterfly side observes the operand set and returns the accept.
  modport slave (
    input  Rea, Ima, Reb, Imb, Rew, Imw, op_valid, load_idx,
    output op_ready
  );
endinterface

// File: rtl/butterfly_operand_loader.sv
// Butterfly input stage: synchronizes, debounces and edge-detects the ReadyIn
// button; each press loads sw into the next operand register; the full set is
// offered on ops with op_valid/op_ready.
// Ports: Clock, Reset (async active-high), ReadyIn (raw button), sw (switch
//        word), LED (last captured word), ops (operand bus, master side).
// Optional macro LOADER_KEEP_W_EN: once the twiddle (Rew/Imw) has been loaded,
// later sets skip it and need only four presses.
module butterfly_operand_loader #(
  parameter int n               = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         ReadyIn,
  input  logic [n-1:0]                 sw,
  output logic [n-1:0]                 LED,
  butterfly_operand_loader_if.master   ops
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_REA   = 3'd0,
    S_IMA   = 3'd1,
    S_REB   = 3'd2,
    S_IMB   = 3'd3,
    S_REW   = 3'd4,
    S_IMW   = 3'd5,
    S_VALID = 3'd6
  } state_t;

  logic          s1, s2;
  logic          stable, stable_q;
  logic [CW-1:0] cnt;
  logic          press;

  state_t        state_q, state_d;
  logic          cap;
  logic          op_valid_q;
  logic [n-1:0]  opr [6];
  logic [n-1:0]  led_q;

  // Synchronizer and debounce: a level change on s2 must persist for
  // DEBOUNCE_CYCLES consecutive cycles before stable follows it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= ReadyIn;
      s2       <= s1;
      stable_q <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the one where the count reaches DEBOUNCE_CYCLES.
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_q;

`ifdef LOADER_KEEP_W_EN
  logic w_loaded;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      w_loaded <= 1'b0;
    end else if (cap && state_q == S_IMW) begin
      w_loaded <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      S_VALID: begin
        // Presses are dropped here; only the accept moves us on.
        if (ops.op_ready) begin
          state_d = S_REA;
        end
      end
      default: begin
        if (press) begin
          cap = 1'b1;
          if (state_q == S_IMW) begin
            state_d = S_VALID;
`ifdef LOADER_KEEP_W_EN
          end else if (state_q == S_IMB && w_loaded) begin
            state_d = S_VALID;
`endif
          end else begin
            state_d = state_t'(state_q + 3'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_REA;
      op_valid_q <= 1'b0;
      led_q      <= '0;
      for (int i = 0; i < 6; i++) begin
        opr[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_valid_q <= (state_d == S_VALID);
      if (cap) begin
        led_q <= sw;
      end
      for (int i = 0; i < 6; i++) begin
        if (cap && state_q == 3'(i)) begin
          opr[i] <= sw;
        end
      end
    end
  end

  assign LED          = led_q;
  assign ops.Rea      = opr[0];
  assign ops.Ima      = opr[1];
  assign ops.Reb      = opr[2];
  assign ops.Imb      = opr[3];
  assign ops.Rew      = opr[4];
  assign ops.Imw      = opr[5];
  assign ops.op_valid = op_valid_q;
  assign ops.load_idx = state_q;

endmodule

// File: tb/tb_butterfly_operand_loader.sv
// Bench for butterfly_operand_loader with DEBOUNCE_CYCLES=4: directed button
// stimulus; expected operand-set snapshots queued per press/accept/reset and
// checked by a monitor whenever load_idx changes.
module tb_butterfly_operand_loader;

  localparam int D = 4;
`ifdef LOADER_KEEP_W_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]      idx;
    logic            valid;
    logic [7:0]      led;
    logic [5:0][7:0] ops;
  } snap_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ReadyIn = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] LED;

  butterfly_operand_loader_if #(.n(8)) bus ();

  butterfly_operand_loader #(.n(8), .DEBOUNCE_CYCLES(D)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .ReadyIn(ReadyIn),
    .sw     (sw),
    .LED    (LED),
    .ops    (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  snap_t sbq[$];

  // Reference model state
  snap_t m;
  bit    m_wl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.idx   = bus.load_idx;
    s.valid = bus.op_valid;
    s.led   = LED;
    s.ops   = {bus.Imw, bus.Imb ^ 8'h00, bus.Rew, bus.Reb, bus.Ima, bus.Rea};
    // Reorder into index order: ops[0]=Rea .. ops[5]=Imw.
    s.ops[0] = bus.Rea; s.ops[1] = bus.Ima; s.ops[2] = bus.Reb;
    s.ops[3] = bus.Imb; s.ops[4] = bus.Rew; s.ops[5] = bus.Imw;
    return s;
  endfunction

  // Monitor: each load_idx change is one DUT response.
  initial begin : monitor
    logic [2:0] prev = 3'd0;
    snap_t e, a;
    forever begin
      @(negedge Clock);
      if (bus.load_idx !== prev) begin
        a = dut_snap();
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got load_idx %0d expected no change", a.idx);
        end else begin
          e = sbq.pop_front();
          check("ev_load_idx", 32'(a.idx), 32'(e.idx));
          check("ev_op_valid", 32'(a.valid), 32'(e.valid));
          check("ev_led", 32'(a.led), 32'(e.led));
          for (int i = 0; i < 6; i++) begin
            check($sformatf("ev_op%0d", i), 32'(a.ops[i]), 32'(e.ops[i]));
          end
        end
        prev = bus.load_idx;
      end
    end
  end

  function automatic void model_press(input logic [7:0] v);
    if (m.idx != 3'd6) begin
      m.ops[m.idx] = v;
      m.led = v;
      if (m.idx == 3'd5) begin
        m.idx = 3'd6; m.valid = 1'b1; m_wl = 1'b1;
      end else if (KEEP && m.idx == 3'd3 && m_wl) begin
        m.idx = 3'd6; m.valid = 1'b1;
      end else begin
        m.idx = m.idx + 3'd1;
      end
      sbq.push_back(m);
    end
  endfunction

  task automatic press(input logic [7:0] v);
    @(negedge Clock);
    sw = v;
    model_press(v);
    ReadyIn = 1'b1;
    repeat (10) @(negedge Clock);
    ReadyIn = 1'b0;
    repeat (10) @(negedge Clock);
  endtask

  task automatic accept();
    @(negedge Clock);
    bus.op_ready = 1'b1;
    if (m.valid) begin
      m.idx = 3'd0; m.valid = 1'b0;
      sbq.push_back(m);
    end
    @(negedge Clock);
    bus.op_ready = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  // Reset asserted mid-cycle, away from both clock edges.
  task automatic do_reset(input string tag);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    if (m.idx != 3'd0) begin
      m = '0; m_wl = 1'b0;
      sbq.push_back(m);
    end else begin
      m = '0; m_wl = 1'b0;
    end
    #1;
    check({tag, "_rea"}, 32'(bus.Rea), 32'h0);
    check({tag, "_reb"}, 32'(bus.Reb), 32'h0);
    check({tag, "_led"}, 32'(LED), 32'h0);
    check({tag, "_valid"}, 32'(bus.op_valid), 32'h0);
    check({tag, "_idx"}, 32'(bus.load_idx), 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  initial begin : stim
    bus.op_ready = 1'b0;
    m = '0;
    m_wl = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Reset state
    check("rst_rea", 32'(bus.Rea), 32'h0);
    check("rst_ima", 32'(bus.Ima), 32'h0);
    check("rst_imw", 32'(bus.Imw), 32'h0);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_valid", 32'(bus.op_valid), 32'h0);
    check("rst_idx", 32'(bus.load_idx), 32'h0);

    // Glitchy button: high 3 / low 1 never survives a 4-cycle debounce.
    sw = 8'h77;
    for (int i = 0; i < 40; i++) begin
      ReadyIn = ((i % 4) != 3);
      @(negedge Clock);
    end
    ReadyIn = 1'b0;
    repeat (10) @(negedge Clock);
    check("glitch_idx", 32'(bus.load_idx), 32'h0);
    check("glitch_rea", 32'(bus.Rea), 32'h0);

    // Accept while nothing is valid is ignored.
    accept();
    check("early_ready_idx", 32'(bus.load_idx), 32'h0);

    // Exact latency: first sampled-high edge E1, capture at E(3+D) = E7.
    @(negedge Clock);
    sw = 8'h3C;
    model_press(8'h3C);
    ReadyIn = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    check("lat_before_idx", 32'(bus.load_idx), 32'h0);
    check("lat_before_rea", 32'(bus.Rea), 32'h0);
    @(posedge Clock);
    #1;
    check("lat_at_idx", 32'(bus.load_idx), 32'h1);
    check("lat_at_rea", 32'(bus.Rea), 32'h3C);
    check("lat_at_led", 32'(LED), 32'h3C);
    repeat (3) @(negedge Clock);
    ReadyIn = 1'b0;
    repeat (10) @(negedge Clock);
    check("one_capture_idx", 32'(bus.load_idx), 32'h1);

    do_reset("rst2");

    // Full six-press set.
    press(8'h01); press(8'h02); press(8'h03);
    press(8'h04); press(8'h05); press(8'hFF);
    check("set_valid", 32'(bus.op_valid), 32'h1);
    check("set_idx", 32'(bus.load_idx), 32'h6);
    press(8'h99);  // ignored while valid
    check("p7_idx", 32'(bus.load_idx), 32'h6);
    check("p7_rea", 32'(bus.Rea), 32'h01);
    check("p7_imw", 32'(bus.Imw), 32'hFF);
    check("p7_led", 32'(LED), 32'hFF);
    accept();
    check("acc_valid", 32'(bus.op_valid), 32'h0);
    check("acc_reb", 32'(bus.Reb), 32'h03);

    // Reset in the middle of a set.
    press(8'hAA); press(8'hBB); press(8'hCC);
    do_reset("rst_mid");
    check("rst_mid_imb", 32'(bus.Imb), 32'h0);
    press(8'h5A);
    check("post_rst_rea", 32'(bus.Rea), 32'h5A);
    check("post_rst_ima", 32'(bus.Ima), 32'h0);
    do_reset("rst3");

    // Twiddle retention: full set, accept, then four presses.
    press(8'h01); press(8'h02); press(8'h03);
    press(8'h04); press(8'h05); press(8'hFF);
    accept();
    press(8'h10); press(8'h20); press(8'h30); press(8'h40);
    check("kw_idx", 32'(bus.load_idx), KEEP ? 32'h6 : 32'h4);
    check("kw_valid", 32'(bus.op_valid), KEEP ? 32'h1 : 32'h0);
    check("kw_imb", 32'(bus.Imb), 32'h40);
    check("kw_rew", 32'(bus.Rew), 32'h05);
    check("kw_imw", 32'(bus.Imw), 32'hFF);

    repeat (5) @(negedge Clock);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
